// File: rtl/sa_tile_sched.sv
// Tile feed scheduler for a ROWS x COLS output-stationary systolic array.
// Generates skewed A/B valid lanes, k indices and clr_acc, then drains and reports completion.
module sa_tile_sched #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_MAX     = 256,
    parameter int DRAIN_LAT = 2,
    localparam int KW       = $clog2(K_MAX + 1),
    localparam int SKEW     = (ROWS > COLS) ? ROWS : COLS,
    localparam int TW       = $clog2(K_MAX + SKEW + DRAIN_LAT + ROWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [KW-1:0]      k_len,
    input  logic               edge_ready,
    output logic [ROWS-1:0]    a_valid,
    output logic [ROWS*KW-1:0] a_kidx,
    output logic [COLS-1:0]    b_valid,
    output logic [COLS*KW-1:0] b_kidx,
    output logic [COLS-1:0]    clr_acc,
    output logic               busy,
    output logic               done,
    output logic [15:0]        tiles_done
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_LAT + ROWS - 2);

    state_t          state;
    logic [TW-1:0]   t;
    logic [KW-1:0]   k_lat;
    logic            feed_last;

    // Last feed cycle: the final lane of the widest skew consumes index k_len-1.
    assign feed_last = (t == TW'(k_lat) + TW'(SKEW - 2));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            t          <= '0;
            k_lat      <= '0;
            tiles_done <= '0;
        end else if (abort) begin
            state <= IDLE;
            t     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat <= k_len;
                        t     <= '0;
                        if (k_len == '0) begin
                            state      <= DONE;
                            tiles_done <= tiles_done + 16'd1;
                        end else begin
                            state <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (edge_ready) begin
                        if (feed_last) begin
                            state <= DRAIN;
                            t     <= '0;
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (t == DRAIN_LAST) begin
                        state      <= DONE;
                        t          <= '0;
                        tiles_done <= tiles_done + 16'd1;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic          feeding;
    logic [TW:0]   t_ext;
    logic [TW:0]   k_ext;

    assign feeding = (state == FEED) && edge_ready;
    assign t_ext   = {1'b0, t};
    assign k_ext   = (TW+1)'(k_lat);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // NOTE: every output of this always_comb is defaulted first so no path
    // leaves a bit unassigned, which would otherwise infer a latch.
    always_comb begin
        a_valid = '0;
        a_kidx  = '0;
        b_valid = '0;
        b_kidx  = '0;
        clr_acc = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (feeding && (t_ext >= (TW+1)'(r)) && (t_ext < (TW+1)'(r) + k_ext)) begin
                a_valid[r]          = 1'b1;
                a_kidx[r*KW +: KW]  = KW'(t - TW'(r));
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (feeding && (t_ext >= (TW+1)'(c)) && (t_ext < (TW+1)'(c) + k_ext)) begin
                b_valid[c]          = 1'b1;
                b_kidx[c*KW +: KW]  = KW'(t - TW'(c));
                clr_acc[c]          = (t == TW'(c));
            end
        end
    end

endmodule

// File: tb/tb_sa_tile_sched.sv
// Directed self-checking bench for sa_tile_sched at ROWS=COLS=4, DRAIN_LAT=2, K_MAX=256.
module tb_sa_tile_sched;

    localparam int KW = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [KW-1:0]     k_len;
    logic              edge_ready;
    logic [3:0]        a_valid;
    logic [4*KW-1:0]   a_kidx;
    logic [3:0]        b_valid;
    logic [4*KW-1:0]   b_kidx;
    logic [3:0]        clr_acc;
    logic              busy;
    logic              done;
    logic [15:0]       tiles_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sa_tile_sched #(.ROWS(4), .COLS(4), .K_MAX(256), .DRAIN_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .k_len      (k_len),
        .edge_ready (edge_ready),
        .a_valid    (a_valid),
        .a_kidx     (a_kidx),
        .b_valid    (b_valid),
        .b_kidx     (b_kidx),
        .clr_acc    (clr_acc),
        .busy       (busy),
        .done       (done),
        .tiles_done (tiles_done)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    typedef struct {
        logic          start;
        logic [KW-1:0] k_len;
        logic          er;
        logic [3:0]    av;
        logic [3:0]    bv;
        logic [3:0]    clr;
        logic          busy;
        logic          done;
        logic [KW-1:0] k0;
        logic [KW-1:0] k3;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t mk(input logic s, input int k, input logic er, input logic [3:0] av,
                                input logic [3:0] clr, input logic bz, input logic dn,
                                input int k0, input int k3);
        vec_t v;
        v.start = s;  v.k_len = KW'(k); v.er = er;
        v.av = av;    v.bv = av;        v.clr = clr;
        v.busy = bz;  v.done = dn;
        v.k0 = KW'(k0); v.k3 = KW'(k3);
        return v;
    endfunction

    int n;
    int clr0_pulses;
    int done_cycle;
    logic [15:0] td_before;
    logic saw_done;

    initial begin
        // Nominal k_len=3 tile; k_len changes and a stray start mid-tile must be ignored.
        vecs[0]  = mk(1, 3, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 7, 1, 4'b0001, 4'b0001, 1, 0, 0, 0);
        vecs[2]  = mk(0, 7, 1, 4'b0011, 4'b0010, 1, 0, 1, 0);
        vecs[3]  = mk(1, 7, 1, 4'b0111, 4'b0100, 1, 0, 2, 0);
        vecs[4]  = mk(0, 7, 1, 4'b1110, 4'b1000, 1, 0, 0, 0);
        vecs[5]  = mk(0, 7, 1, 4'b1100, 4'b0000, 1, 0, 0, 1);
        vecs[6]  = mk(0, 7, 1, 4'b1000, 4'b0000, 1, 0, 0, 2);
        vecs[7]  = mk(0, 7, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[8]  = mk(0, 7, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[9]  = mk(0, 7, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[10] = mk(0, 7, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[11] = mk(0, 7, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[12] = mk(0, 7, 1, 4'b0000, 4'b0000, 1, 1, 0, 0);
        vecs[13] = mk(0, 7, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        // k_len=3 tile with edge_ready low in cycles 2-3.
        vecs[14] = mk(1, 3, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
        vecs[15] = mk(0, 3, 1, 4'b0001, 4'b0001, 1, 0, 0, 0);
        vecs[16] = mk(0, 3, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[17] = mk(0, 3, 0, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[18] = mk(0, 3, 1, 4'b0011, 4'b0010, 1, 0, 1, 0);
        vecs[19] = mk(0, 3, 1, 4'b0111, 4'b0100, 1, 0, 2, 0);
        vecs[20] = mk(0, 3, 1, 4'b1110, 4'b1000, 1, 0, 0, 0);
        vecs[21] = mk(0, 3, 1, 4'b1100, 4'b0000, 1, 0, 0, 1);
        vecs[22] = mk(0, 3, 1, 4'b1000, 4'b0000, 1, 0, 0, 2);
        for (int i = 23; i < 28; i++) vecs[i] = mk(0, 3, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
        vecs[28] = mk(0, 3, 1, 4'b0000, 4'b0000, 1, 1, 0, 0);
        vecs[29] = mk(0, 3, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0; edge_ready = 1'b1;
        sample();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", {a_valid, b_valid, clr_acc}, 0);
        check("reset_kidx", {a_kidx, b_kidx}, 0);
        check("reset_tiles", tiles_done, 0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            start = vecs[i].start; k_len = vecs[i].k_len; edge_ready = vecs[i].er;
            sample();
            check($sformatf("v%0d_a_valid", i), a_valid, vecs[i].av);
            check($sformatf("v%0d_b_valid", i), b_valid, vecs[i].bv);
            check($sformatf("v%0d_clr_acc", i), clr_acc, vecs[i].clr);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            check($sformatf("v%0d_a_kidx0", i), a_kidx[0 +: KW], vecs[i].k0);
            check($sformatf("v%0d_b_kidx3", i), b_kidx[3*KW +: KW], vecs[i].k3);
            tick();
        end
        start = 1'b0; edge_ready = 1'b1;
        check("tiles_after_table", tiles_done, 2);

        // k_len=0 goes straight to DONE with no valids.
        start = 1'b1; k_len = '0;
        tick();
        start = 1'b0; k_len = KW'(5);
        sample();
        check("k0_done", done, 1);
        check("k0_valid", {a_valid, b_valid, clr_acc}, 0);
        tick();
        sample();
        check("k0_idle", {busy, done}, 0);
        check("k0_tiles", tiles_done, 3);

        // Abort at cycle 4 of a k_len=8 tile.
        td_before = tiles_done;
        tick();
        start = 1'b1; k_len = KW'(8);
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        sample();
        check("abort_c4_busy", busy, 1);
        tick();
        abort = 1'b0;
        sample();
        check("abort_c5_busy", busy, 0);
        check("abort_c5_out", {a_valid, b_valid, clr_acc, done}, 0);
        check("abort_c5_kidx", {a_kidx, b_kidx}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            sample();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_tiles", tiles_done, td_before);

        // Abort beats start in IDLE.
        tick();
        start = 1'b1; abort = 1'b1; k_len = KW'(2);
        tick();
        start = 1'b0; abort = 1'b0;
        sample();
        check("abort_wins_start", busy, 0);

        // Asynchronous reset during FEED, then a fresh k_len=1 tile.
        tick();
        start = 1'b1; k_len = KW'(8);
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        sample();
        check("rst_pre_valid", a_valid != 4'b0000, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out", {a_valid, b_valid, clr_acc, busy, done}, 0);
        check("rst_async_kidx", {a_kidx, b_kidx}, 0);
        check("rst_async_tiles", tiles_done, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        sample();
        check("rst_stays_idle", busy, 0);
        tick();
        start = 1'b1; k_len = KW'(1);
        tick();
        start = 1'b0;
        done_cycle = -1;
        for (n = 1; n <= 30; n++) begin
            sample();
            if (done) begin
                done_cycle = n;
                break;
            end
            tick();
        end
        check("rst_k1_done_cycle", done_cycle, 10);

        // Two back-to-back k_len=2 tiles after a fresh reset.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clr0_pulses = 0;
        start = 1'b1; k_len = KW'(2);
        tick();
        start = 1'b0;
        done_cycle = -1;
        for (n = 1; n <= 30; n++) begin
            sample();
            if (clr_acc[0]) clr0_pulses++;
            if (done) begin
                done_cycle = n;
                break;
            end
            tick();
        end
        check("b2b_first_done", done_cycle, 11);
        tick();
        start = 1'b1; k_len = KW'(2);
        sample();
        check("b2b_idle_after_done", busy, 0);
        tick();
        start = 1'b0;
        done_cycle = -1;
        for (n = 1; n <= 30; n++) begin
            sample();
            if (clr_acc[0]) clr0_pulses++;
            if (done) begin
                done_cycle = n;
                break;
            end
            tick();
        end
        check("b2b_second_done", done_cycle, 11);
        tick();
        sample();
        check("b2b_tiles", tiles_done, 2);
        check("b2b_clr0_pulses", clr0_pulses, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sa_tile_sched.md
SA_TILE_SCHED -- requirements
Module: sa_tile_sched

Interface — parameters
REQ-001 SHALL have parameter ROWS, default 4, giving the PE rows of the array (one A feed lane per row).
REQ-002 SHALL have parameter COLS, default 4, giving the PE columns (one B feed lane and one top-row clr_acc per column).
REQ-003 SHALL have parameter K_MAX, default 256, giving the largest reduction length accepted.
REQ-004 SHALL have parameter DRAIN_LAT, default 2, giving the PE MAC-plus-accumulator-stage latency in cycles.
REQ-005 SHALL use derived widths KW = clog2(K_MAX+1), SKEW = max(ROWS,COLS) and TW = clog2(K_MAX+SKEW+DRAIN_LAT+ROWS).

Interface — ports
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: tile launch request, sampled in IDLE only.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel of the current tile.
REQ-010 SHALL have port k_len, input, KW bits: reduction length, captured when start is accepted.
REQ-011 SHALL have port edge_ready, input, 1 bit: AND of all array-edge ready_in_a/ready_in_b; low means stall.
REQ-012 SHALL have port a_valid, output, ROWS bits: valid_in_a for the west-edge PE of each row.
REQ-013 SHALL have port a_kidx, output, ROWS*KW bits: operand k index per row, row r at bits [r*KW +: KW].
REQ-014 SHALL have port b_valid, output, COLS bits: valid_in_b for the north-edge PE of each column.
REQ-015 SHALL have port b_kidx, output, COLS*KW bits: operand k index per column.
REQ-016 SHALL have port clr_acc, output, COLS bits: clr_acc for the top-row PE of each column.
REQ-017 SHALL have port busy, output, 1 bit: high in FEED, DRAIN and DONE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle tile-complete pulse.
REQ-019 SHALL have port tiles_done, output, 16 bits: count of completed tiles, wrapping from 0xFFFF to 0.

Function
REQ-020 SHALL implement the FSM states IDLE, FEED, DRAIN and DONE, with a registered state and a TW-bit cycle counter t.
REQ-021 SHALL, in IDLE with start=1 and k_len≠0, latch k_len, clear t and enter FEED on the next cycle.
REQ-022 SHALL, in IDLE with start=1 and k_len=0, enter DONE directly, asserting no valids.
REQ-023 SHALL, in FEED, increment t only when edge_ready=1; when edge_ready=0, t holds and all a_valid/b_valid/clr_acc are 0.
REQ-024 SHALL drive a_valid[r] = FEED & edge_ready & (r ≤ t < r+k_len), with a_kidx[r] = t−r when valid and 0 otherwise.
REQ-025 SHALL drive b_valid[c] = FEED & edge_ready & (c ≤ t < c+k_len), with b_kidx[c] = t−c when valid and 0 otherwise.
REQ-026 SHALL assert clr_acc[c] exactly in the FEED cycle where b_valid[c]=1 and b_kidx[c]=0.
REQ-027 SHALL leave FEED for DRAIN after the advancing cycle with t = k_len+SKEW−2, clearing t on entry to DRAIN.
REQ-028 SHALL hold DRAIN for DRAIN_LAT+ROWS−1 cycles, ignoring edge_ready, then enter DONE.
REQ-029 SHALL hold DONE for exactly one cycle with done=1 and tiles_done incremented, then return to IDLE.
REQ-030 SHALL compute all outputs combinationally from the registered state, t and the latched k_len.
REQ-031 SHALL ignore start outside IDLE; a changing k_len input SHALL not affect a tile in flight.
REQ-032 SHALL, on abort=1 in any state, return to IDLE next cycle with no done pulse and no tiles_done change; abort wins over start in the same cycle.
REQ-033 SHALL accept start=1 in the IDLE cycle immediately after DONE (back-to-back tiles).

Reset
REQ-034 SHALL, while rst_n=0, force state=IDLE, t=0, latched k_len=0 and tiles_done=0, with a_valid, b_valid, clr_acc, busy, done, a_kidx and b_kidx all 0.
REQ-035 SHALL, when reset asserts mid-tile, abandon the tile immediately with no done pulse, and resume only on a fresh start after release.

Verification (ROWS=COLS=4, DRAIN_LAT=2, start at cycle 0, edge_ready=1 unless stated)
REQ-036 SHALL cover nominal k_len=3 -> FEED cycles 1–6; a_valid[0] at cycles 1–3 with kidx 0,1,2; a_valid[3] at cycles 4–6; clr_acc[2] only at cycle 3; DRAIN cycles 7–11; done=1 at cycle 12; tiles_done=1.
REQ-037 SHALL cover a stall where edge_ready=0 at cycles 2–3 of the k_len=3 tile -> no valids in cycles 2–3; a_valid[0] kidx=1 at cycle 4; done at cycle 14.
REQ-038 SHALL cover k_len=0 -> done=1 at cycle 1, no valid asserted, tiles_done increments.
REQ-039 SHALL cover abort at cycle 4 of a k_len=8 tile -> IDLE at cycle 5, all outputs 0, no done pulse, tiles_done unchanged.
REQ-040 SHALL cover rst_n low at cycle 5 during FEED -> all outputs 0 asynchronously; after release, a start at k_len=1 gives a done pulse at cycle +10.
REQ-041 SHALL cover two back-to-back k_len=2 tiles -> second start accepted the cycle after the first done; tiles_done=2; clr_acc[0] pulses once per tile.
